sha1_msg_pad: RTL and testbench
===============================

# sha1_msg_pad

- Upstream feeder for the SHA-1 compression stage.
- Reads a byte-length message from the shared dual-port SRAM, one 32-bit word at a time.
- Applies FIPS 180 padding: 0x80 byte, zero fill, 64-bit big-endian bit length.
- Delivers the padded message to the hash core as a valid/ready stream of 32-bit words in 512-bit (16-word) blocks.

## Interface
- Parameters:
- ADDR_W, 16, width of the SRAM word address.
- Ports:
- clk  in  1  sole clock; also drives mem_clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches message_addr and message_size; ignored while busy.
- message_addr  in  32  word address of the first message word; bits [ADDR_W-1:0] used.
- message_size  in  32  message length in bytes (0 allowed).
- mem_clk  out  1  equals clk.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_we  out  1  constant 0 (read-only port).
- mem_rdata  in  32  SRAM read data; valid exactly one cycle after mem_addr.
- w_data  out  32  padded message word, big-endian byte order.
- w_valid  out  1  w_data valid; held until accepted.
- w_ready  in  1  consumer accepts the word when w_valid && w_ready.
- w_first  out  1  with w_valid: word 0 of a block.
- w_last  out  1  with w_valid: word 15 of a block.
- msg_last  out  1  with w_valid: word belongs to the final block.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- Definitions, with S = latched message_size:
  - nblk = floor((S+8)/64)+1.
  - total = 16*nblk words.
  - Word index i counts 0..total-1 (32-bit counter).
  - q = S>>2, r = S[1:0].
- Word content for index i:
  - i<q: memory word at message_addr+i.
  - i==q, r!=0: memory word at message_addr+i; keep top r bytes, byte r = 0x80, lower bytes 0.
  - i==q, r==0: 0x80000000; no memory read.
  - q<i<total-2: 0x00000000.
  - i==total-2: {29'b0, S[31:29]}.
  - i==total-1: {S[28:0], 3'b000}.
- FSM states: IDLE, ADDR, CAPT, OUT, DONE.
  - IDLE: on start, latch inputs, clear i, then go to ADDR if word 0 needs memory, else OUT.
  - ADDR: drive mem_addr = (message_addr+i) mod 2^ADDR_W, then go to CAPT.
  - CAPT: register the formatted mem_rdata into w_data, then go to OUT.
  - OUT: w_valid=1. On handshake at i==total-1, go to DONE. On other handshakes, increment i, then go to ADDR if the new word needs memory, else stay in OUT with the generated word loaded.
  - DONE: done=1 for one cycle, then go to IDLE.
- mem_addr wraps modulo 2^ADDR_W.
- Flags are derived from i: w_first = (i[3:0]==0), w_last = (i[3:0]==15), msg_last = (i >= total-16).

## Timing
- Reset values: every output 0 (w_data, w_valid, w_first, w_last, msg_last, busy, done, mem_addr, mem_we); FSM in IDLE; i=0.
- Reset mid-operation aborts the message: everything returns to reset values in the next cycle, and no done is produced.
- Memory word:
  - start at cycle t, mem_addr at t+1.
  - mem_rdata at t+2, captured into w_data.
  - w_valid at t+3.
- Generated word: w_valid the cycle after the previous handshake.
- w_data and all flags stay stable while w_valid && !w_ready.
- done asserts the cycle after the final handshake; busy falls in that same cycle.
- start is accepted the cycle after done.
- start during busy (including the DONE cycle) has no effect.

## Configuration
- SHA1_PAD_BSWAP_EN defined: mem_rdata is byte-swapped ({b0,b1,b2,b3}) before masking and padding; used for little-endian SRAM images.
- SHA1_PAD_BSWAP_EN undefined: mem_rdata is used as-is, with byte 0 in bits [31:24].
- Generated words are never swapped.

## Structure
- Shared package sha1_pkg holds:
  - SHA1_BLOCK_WORDS=16.
  - SHA1_PAD_BYTE=8'h80.
  - The FSM state enum, reused by the hash core bench.
- Sub-module sha1_pad_word: purely combinational word formatter. Inputs are i, S, mem_rdata; outputs are the formatted word and a needs_mem flag. The top level holds the FSM, counters and registers.

## Test plan
- "abc", S=3, memory 0x61626300:
  - w0=0x61626380, w1..w14=0, w15=0x00000018.
  - 16 words, msg_last on all of them, then one done pulse.
- S=0:
  - No memory reads.
  - w0=0x80000000, w1..w15=0.
- S=55 and S=56: 16 and 32 words respectively.
  - S=56 block 0: w14=0x80000000 (r=0), w15=0.
  - S=56 block 1: w15=0x000001C0.
- Random w_ready deasserts across a 3-block message: no word dropped or duplicated, and data and flags are held stable while stalled.
- message_addr=0xFFFE, S=12: mem_addr sequence is 0xFFFE, 0xFFFF, 0x0000.
- Reset asserted mid-block: outputs are 0 the next cycle, no done; a new start then produces a correct full stream.
- With SHA1_PAD_BSWAP_EN, memory 0x00636261 for "abc": same w0=0x61626380.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, pad byte, feeder FSM state enum
// and small helpers used by the message padder and the hash core bench.
package sha1_pkg;

   localparam int         SHA1_BLOCK_WORDS = 16;
   localparam logic [7:0] SHA1_PAD_BYTE    = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_CAPT = 3'd2,
      ST_OUT  = 3'd3,
      ST_DONE = 3'd4
   } sha1_pad_state_e;

   // Number of 32-bit words in the padded message of 'size' bytes.
   // Carried in 34 bits so sizes near 2^32 cannot wrap.
   function automatic logic [33:0] sha1_total_words(input logic [31:0] size);
      logic [33:0] nblk;
      nblk = (({2'b00, size} + 34'd8) >> 6) + 34'd1;
      return nblk * 34'(SHA1_BLOCK_WORDS);
   endfunction

   // Reverse the byte order of a 32-bit word.
   function automatic logic [31:0] sha1_bswap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/sha1_msg_pad_if.sv
// Padded-word stream from the message padder to the SHA-1 hash core.
interface sha1_msg_pad_if;
   logic [31:0] w_data;
   logic        w_valid;
   logic        w_ready;
   logic        w_first;
   logic        w_last;
   logic        msg_last;

   modport master (output w_data, output w_valid, output w_first,
                   output w_last, output msg_last, input w_ready);
   modport slave  (input w_data, input w_valid, input w_first,
                   input w_last, input msg_last, output w_ready);
endinterface

// File: rtl/sha1_pad_word.sv
// Combinational formatter: produces padded word i of a message of i_size
// bytes from the raw SRAM word, and flags whether that word needs a read.
// Build option SHA1_PAD_BSWAP_EN: byte-swap SRAM data (little-endian images).
module sha1_pad_word import sha1_pkg::*; (
   input  logic [31:0] i_idx,
   input  logic [31:0] i_size,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_word,
   output logic        o_needs_mem
);

   logic [31:0] w_q;
   logic [1:0]  w_r;
   logic [33:0] w_total;
   logic [33:0] w_idx34;
   logic [31:0] w_rdata;

   assign w_q     = {2'b00, i_size[31:2]};
   assign w_r     = i_size[1:0];
   assign w_total = sha1_total_words(i_size);
   assign w_idx34 = {2'b00, i_idx};

`ifdef SHA1_PAD_BSWAP_EN
   assign w_rdata = sha1_bswap32(i_mem_rdata);
`else
   assign w_rdata = i_mem_rdata;
`endif

   // Select message data, the 0x80 terminator, zero fill or the bit length.
   always_comb begin
      o_word      = 32'h0000_0000;
      o_needs_mem = 1'b0;
      if (i_idx < w_q) begin
         o_word      = w_rdata;
         o_needs_mem = 1'b1;
      end else if (i_idx == w_q) begin
         o_needs_mem = (w_r != 2'd0);
         case (w_r)
            2'd0:    o_word = {SHA1_PAD_BYTE, 24'h00_0000};
            2'd1:    o_word = {w_rdata[31:24], SHA1_PAD_BYTE, 16'h0000};
            2'd2:    o_word = {w_rdata[31:16], SHA1_PAD_BYTE, 8'h00};
            2'd3:    o_word = {w_rdata[31:8], SHA1_PAD_BYTE};
            default: o_word = 32'h0000_0000;
         endcase
      end else if (w_idx34 == (w_total - 34'd1)) begin
         o_word = {i_size[28:0], 3'b000};
      end else if (w_idx34 == (w_total - 34'd2)) begin
         o_word = {29'h0000_0000, i_size[31:29]};
      end else begin
         o_word = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/sha1_msg_pad.sv
// SHA-1 message padder: reads a byte-length message from SRAM word by word
// and streams the FIPS 180 padded message as 16-word blocks.
// Build option SHA1_PAD_BSWAP_EN (in sha1_pad_word): byte-swap SRAM data.
module sha1_msg_pad import sha1_pkg::*; #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       message_addr,
   input  logic [31:0]       message_size,
   output logic              mem_clk,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   sha1_msg_pad_if.master    w_if,
   output logic              busy,
   output logic              done
);

   sha1_pad_state_e   r_state;
   sha1_pad_state_e   w_state_nxt;
   logic [31:0]       r_i;
   logic [31:0]       r_size;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_w_data;

   logic [31:0]       w_fmt_idx;
   logic [31:0]       w_fmt_size;
   logic [31:0]       w_fmt_word;
   logic              w_needs_mem;
   logic [33:0]       w_total;
   logic [31:0]       w_idx_inc;
   logic              w_hs;
   logic              w_at_last;
   logic              w_unused_addr_hi;

   assign mem_clk          = clk;
   assign mem_we           = 1'b0;
   assign mem_addr         = r_mem_addr;
   assign w_if.w_data      = r_w_data;
   assign w_unused_addr_hi = ^message_addr[31:ADDR_W];

   assign w_total   = sha1_total_words(r_size);
   assign w_idx_inc = r_i + 32'd1;
   assign w_hs      = (r_state == ST_OUT) && w_if.w_ready;
   assign w_at_last = ({2'b00, r_i} == (w_total - 34'd1));

   // Formatter looks at word 0 of the new message while idle, the next
   // word while presenting one, and the current word while capturing.
   always_comb begin
      w_fmt_idx  = r_i;
      w_fmt_size = r_size;
      if (r_state == ST_IDLE) begin
         w_fmt_idx  = 32'd0;
         w_fmt_size = message_size;
      end else if (r_state == ST_OUT) begin
         w_fmt_idx  = w_idx_inc;
         w_fmt_size = r_size;
      end else begin
         w_fmt_idx  = r_i;
         w_fmt_size = r_size;
      end
   end

   sha1_pad_word u_fmt (
      .i_idx       (w_fmt_idx),
      .i_size      (w_fmt_size),
      .i_mem_rdata (mem_rdata),
      .o_word      (w_fmt_word),
      .o_needs_mem (w_needs_mem)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: fetch from memory only for words that carry message bytes.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = w_needs_mem ? ST_ADDR : ST_OUT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ADDR: w_state_nxt = ST_CAPT;
         ST_CAPT: w_state_nxt = ST_OUT;
         ST_OUT: begin
            if (w_hs && w_at_last) begin
               w_state_nxt = ST_DONE;
            end else if (w_hs) begin
               w_state_nxt = w_needs_mem ? ST_ADDR : ST_OUT;
            end else begin
               w_state_nxt = ST_OUT;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: stream handshake, block flags and status decoded from state and i.
   always_comb begin
      w_if.w_valid  = (r_state == ST_OUT);
      w_if.w_first  = (r_state == ST_OUT) && (r_i[3:0] == 4'd0);
      w_if.w_last   = (r_state == ST_OUT) && (r_i[3:0] == 4'd15);
      w_if.msg_last = (r_state == ST_OUT) &&
                      ({2'b00, r_i} >= (w_total - 34'(SHA1_BLOCK_WORDS)));
      busy          = (r_state == ST_ADDR) || (r_state == ST_CAPT) || (r_state == ST_OUT);
      done          = (r_state == ST_DONE);
   end

   // Datapath: latch the request, advance i, issue reads and load output words.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_i        <= 32'd0;
         r_size     <= 32'd0;
         r_base     <= {ADDR_W{1'b0}};
         r_mem_addr <= {ADDR_W{1'b0}};
         r_w_data   <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_size <= message_size;
                  r_base <= message_addr[ADDR_W-1:0];
                  r_i    <= 32'd0;
                  if (w_needs_mem) begin
                     r_mem_addr <= message_addr[ADDR_W-1:0];
                  end else begin
                     r_w_data <= w_fmt_word;
                  end
               end
            end
            ST_CAPT: r_w_data <= w_fmt_word;
            ST_OUT: begin
               if (w_hs && !w_at_last) begin
                  r_i <= w_idx_inc;
                  if (w_needs_mem) begin
                     r_mem_addr <= r_base + w_idx_inc[ADDR_W-1:0];
                  end else begin
                     r_w_data <= w_fmt_word;
                  end
               end
            end
            default: begin
               r_i <= r_i;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_msg_pad.sv
// Self-checking bench for sha1_msg_pad: byte-level padding model, random
// back-pressure, pinned known-answer words, reset abort and address wrap.
module tb_sha1_msg_pad;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] message_addr;
   logic [31:0] message_size;
   logic        mem_clk;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   sha1_msg_pad_if w_if();

   sha1_msg_pad #(.ADDR_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .message_addr (message_addr),
      .message_size (message_size),
      .mem_clk      (mem_clk),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .w_if         (w_if.master),
      .busy         (busy),
      .done         (done)
   );

   logic [31:0] mem [0:65535];

   // SRAM model: read data one cycle after the address.
   always @(posedge clk) mem_rdata <= mem[mem_addr];

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_w [0:255];
   int          exp_n;
   logic [31:0] got   [0:255];
   int          got_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
      end
   endtask

   // Memory word in message byte order (first message byte in [31:24]).
   function automatic logic [31:0] msg_word(input logic [15:0] a);
      logic [31:0] w;
      w = mem[a];
`ifdef SHA1_PAD_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [7:0] msg_byte(input logic [31:0] base, input int k);
      logic [15:0] a;
      logic [31:0] w;
      int          p;
      a = base[15:0] + 16'(k / 4);
      w = msg_word(a);
      p = k % 4;
      return w[31-8*p -: 8];
   endfunction

   // Padded message as bytes, then regrouped big-endian into words.
   task automatic build_model(input logic [31:0] base, input int s);
      logic [7:0]  b [0:1023];
      int          nbytes;
      logic [63:0] len;
      nbytes = 64;
      while (nbytes < s + 9) nbytes += 64;
      for (int k = 0; k < nbytes; k++) begin
         if (k < s)       b[k] = msg_byte(base, k);
         else if (k == s) b[k] = 8'h80;
         else             b[k] = 8'h00;
      end
      len = 64'(s) * 64'd8;
      for (int j = 0; j < 8; j++) b[nbytes-8+j] = len[63-8*j -: 8];
      exp_n = nbytes / 4;
      for (int i = 0; i < exp_n; i++)
         exp_w[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
   endtask

   // One message: start, consume with random stalls, check every presented word.
   task automatic run_msg(input logic [31:0] base, input int s, input int stall_pct, input int abort_at);
      int          idx;
      int          cyc;
      logic        prev_stall;
      logic        poked;
      logic        rdy;
      logic [31:0] pd;
      logic [2:0]  pf;
      logic [15:0] ma0;
      build_model(base, s);
      got_n        = 0;
      start        = 1'b1;
      message_addr = base;
      message_size = 32'(s);
      @(posedge clk); #1;
      start = 1'b0;
      ma0   = mem_addr;
      chk1("busy_after_start", busy, 1'b1);
      idx = 0; cyc = 0; prev_stall = 1'b0; poked = 1'b0; pd = 32'd0; pf = 3'd0;
      while (idx < exp_n && cyc < 4000) begin
         if (abort_at >= 0 && idx == abort_at) begin
            w_if.w_ready = 1'b0;
            start        = 1'b0;
            reset        = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk1("abort_valid", w_if.w_valid, 1'b0);
            chk ("abort_data", w_if.w_data, 32'd0);
            chk ("abort_flags", {29'd0, w_if.w_first, w_if.w_last, w_if.msg_last}, 32'd0);
            chk ("abort_mem_addr", {16'd0, mem_addr}, 32'd0);
            chk1("abort_busy", busy, 1'b0);
            chk1("abort_done", done, 1'b0);
            repeat (4) begin
               @(posedge clk); #1;
               chk1("abort_no_done", done, 1'b0);
            end
            return;
         end
         chk1("busy_mid", busy, 1'b1);
         chk1("done_mid", done, 1'b0);
         if (s == 0) chk("no_mem_read", {16'd0, mem_addr}, {16'd0, ma0});
         start = 1'b0;
         if (!poked && idx == 3) begin
            start        = 1'b1;
            message_addr = 32'h0000_1234;
            message_size = 32'd7;
            poked        = 1'b1;
         end
         if (prev_stall) begin
            chk1("hold_valid", w_if.w_valid, 1'b1);
            chk ("hold_data", w_if.w_data, pd);
            chk ("hold_flags", {29'd0, w_if.w_first, w_if.w_last, w_if.msg_last}, {29'd0, pf});
         end
         if (w_if.w_valid) begin
            chk ("word_data", w_if.w_data, exp_w[idx]);
            chk1("w_first", w_if.w_first, (idx % 16) == 0);
            chk1("w_last", w_if.w_last, (idx % 16) == 15);
            chk1("msg_last", w_if.msg_last, idx >= exp_n - 16);
            rdy        = ($urandom_range(99) >= 32'(stall_pct));
            pd         = w_if.w_data;
            pf         = {w_if.w_first, w_if.w_last, w_if.msg_last};
            prev_stall = !rdy;
            if (rdy) begin
               got[idx] = w_if.w_data;
               idx++;
            end
         end else begin
            rdy        = 1'($urandom_range(1));
            prev_stall = 1'b0;
         end
         w_if.w_ready = rdy;
         @(posedge clk); #1;
         cyc++;
      end
      start        = 1'b0;
      w_if.w_ready = 1'b0;
      got_n        = idx;
      chk1("cycle_budget", cyc >= 4000, 1'b0);
      chk1("done_pulse", done, 1'b1);
      chk1("busy_at_done", busy, 1'b0);
      chk1("valid_at_done", w_if.w_valid, 1'b0);
      // A start during the DONE cycle must be ignored.
      start        = 1'b1;
      message_size = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      chk1("done_one_cycle", done, 1'b0);
      chk1("start_in_done_ignored", busy, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      reset        = 1'b1;
      start        = 1'b0;
      message_addr = 32'd0;
      message_size = 32'd0;
      w_if.w_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_valid", w_if.w_valid, 1'b0);
      chk ("rst_data", w_if.w_data, 32'd0);
      chk ("rst_flags", {29'd0, w_if.w_first, w_if.w_last, w_if.msg_last}, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk ("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk1("mem_we", mem_we, 1'b0);
      chk1("mem_clk", mem_clk, clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // "abc"
`ifdef SHA1_PAD_BSWAP_EN
      mem[16'h0100] = 32'h0063_6261;
`else
      mem[16'h0100] = 32'h6162_6300;
`endif
      run_msg(32'h0000_0100, 3, 0, -1);
      chk("abc_count", 32'(got_n), 32'd16);
      chk("abc_w0", got[0], 32'h6162_6380);
      chk("abc_w1", got[1], 32'h0000_0000);
      chk("abc_w14", got[14], 32'h0000_0000);
      chk("abc_w15", got[15], 32'h0000_0018);

      // empty message
      run_msg(32'h0000_2000, 0, 25, -1);
      chk("s0_count", 32'(got_n), 32'd16);
      chk("s0_w0", got[0], 32'h8000_0000);
      chk("s0_w15", got[15], 32'h0000_0000);

      // one-block boundary
      run_msg(32'h0000_3000, 55, 0, -1);
      chk("s55_count", 32'(got_n), 32'd16);
      chk("s55_w15", got[15], 32'h0000_01B8);

      run_msg(32'h0000_4000, 56, 20, -1);
      chk("s56_count", 32'(got_n), 32'd32);
      chk("s56_w14", got[14], 32'h8000_0000);
      chk("s56_w15", got[15], 32'h0000_0000);
      chk("s56_w31", got[31], 32'h0000_01C0);

      // three blocks under heavy back-pressure
      run_msg(32'h0000_5000, 150, 40, -1);
      chk("s150_count", 32'(got_n), 32'd48);

      // address wrap
      run_msg(32'h0000_FFFE, 12, 0, -1);
      chk("wrap_w0", got[0], msg_word(16'hFFFE));
      chk("wrap_w1", got[1], msg_word(16'hFFFF));
      chk("wrap_w2", got[2], msg_word(16'h0000));

      // reset mid-block, then a clean run
      run_msg(32'h0000_6000, 100, 30, 20);
      run_msg(32'h0000_6000, 100, 30, -1);
      chk("after_abort_count", 32'(got_n), 32'd32);

      // random messages
      repeat (6) run_msg($urandom, int'($urandom_range(0, 200)), 30, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
